mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the processor's data-memory bus, directly downstream of the single-cycle ARM core. It decodes the core's `MemWrite`/`ALUResult`/`WriteData` outputs against a fixed base address and buffers bytes in a small FIFO. It serialises those bytes as 8N1 frames on `tx`. Reads return status combinationally, so the top-level `ReadData` mux can select them within the same cycle.

---
 rtl/mmio_uart_pkg.sv | 38 +++
 rtl/mmio_uart_tx_if.sv | 24 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 61 ++++++
 rtl/mmio_uart_tx.sv | 157 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - register map, STATUS layout and FSM state type for the MMIO UART transmitter
package mmio_uart_pkg;

   // Register offsets are word indices taken from ALUResult[3:2]
   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;
   localparam logic [1:0] OFF_DROPS  = 2'd3;

   localparam int STAT_FULL      = 0;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_COUNT_LSB = 8;
   localparam int STAT_COUNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   function automatic logic [31:0] status_word(
      input logic                    full,
      input logic                    empty,
      input logic                    busy,
      input logic [STAT_COUNT_W-1:0] count
   );
      logic [31:0] s;
      s                                   = '0;
      s[STAT_FULL]                        = full;
      s[STAT_EMPTY]                       = empty;
      s[STAT_BUSY]                        = busy;
      s[STAT_COUNT_LSB +: STAT_COUNT_W]   = count;
      return s;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - core data-memory bus as seen by the UART register window
interface mmio_uart_tx_if;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic        Sel;
   logic [31:0] RdData;

   modport master (
      output MemWrite,
      output ALUResult,
      output WriteData,
      input  Sel,
      input  RdData
   );

   modport slave (
      input  MemWrite,
      input  ALUResult,
      input  WriteData,
      output Sel,
      output RdData
   );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// rtl/mmio_uart_tx_sync_fifo.sv - single-clock FIFO; push while full and pop while empty are ignored
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Full/empty come from the pre-edge count, so a pop cannot make room for a same-cycle push
   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign dout      = r_mem[r_rd_ptr];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= ptr_next(r_wr_ptr);
         if (w_do_pop)
            r_rd_ptr <= ptr_next(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter: address decode, CTRL/DROPS, read mux, TX FSM
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic         clk,
   input  logic         reset,
   mmio_uart_tx_if.slave bus,
   output logic         tx
);

   localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
   localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic             w_sel;
   logic [1:0]       w_off;
   logic             w_wr;
   logic             w_push_req;
   logic             w_drop;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [CW-1:0]    w_count;
   logic [7:0]       w_dout;
   logic             w_bit_end;
   logic             w_busy;
   logic             w_unused;

   logic             r_enable;
   logic [7:0]       r_drops;
   uart_state_t      r_state;
   logic [CNT_W-1:0] r_clk_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_tx;

   assign w_sel      = (bus.ALUResult[31:4] == BASE_ADDR[31:4]);
   assign w_off      = bus.ALUResult[3:2];
   assign w_wr       = bus.MemWrite && w_sel;
   assign w_push_req = w_wr && (w_off == OFF_TXDATA);
   assign w_drop     = w_push_req && w_full;
   assign w_bit_end  = (r_clk_cnt == CNT_LAST);
   assign w_busy     = (r_state != IDLE);
   assign w_unused   = ^{bus.ALUResult[1:0], bus.WriteData[31:8]};

   // A new byte is taken either from idle or on the final stop-bit cycle, which makes frames contiguous
   assign w_pop = r_enable && !w_empty &&
                  ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push_req && !w_full),
      .pop   (w_pop),
      .din   (bus.WriteData[7:0]),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   assign bus.Sel = w_sel;

   always_comb begin
      bus.RdData = '0;
      if (w_sel) begin
         case (w_off)
            OFF_STATUS: bus.RdData = status_word(w_full, w_empty, w_busy, STAT_COUNT_W'(w_count));
            OFF_CTRL:   bus.RdData = {31'd0, r_enable};
            OFF_DROPS:  bus.RdData = {24'd0, r_drops};
            default:    bus.RdData = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_enable <= 1'b0;
         r_drops  <= '0;
      end else begin
         if (w_wr && (w_off == OFF_CTRL))
            r_enable <= bus.WriteData[0];
         if (w_wr && (w_off == OFF_DROPS))
            r_drops <= '0;
         else if (w_drop && (r_drops != 8'hFF))
            r_drops <= r_drops + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_clk_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         if (r_state != IDLE)
            r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_shift <= w_dout;
                  r_state <= START;
                  r_tx    <= 1'b0;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_state   <= DATA;
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
               end
            end
            DATA: begin
               // Shift register consumes one bit per boundary; r_shift[1] is the next bit out
               if (w_bit_end) begin
                  if (r_bit_idx == 3'd7) begin
                     r_state <= STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_tx      <= r_shift[1];
                  end
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  if (w_pop) begin
                     r_shift <= w_dout;
                     r_state <= START;
                     r_tx    <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                     r_tx    <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign tx = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx with vector table, corner sequences and random traffic
module tb_mmio_uart_tx;

   localparam int          CPB   = 4;
   localparam int          FRAME = 10 * CPB;
   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam logic [31:0] A_TX  = BASE + 32'h0;
   localparam logic [31:0] A_ST  = BASE + 32'h4;
   localparam logic [31:0] A_CT  = BASE + 32'h8;
   localparam logic [31:0] A_DR  = BASE + 32'hC;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic tx;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          wr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic        exp_sel;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vt [13];

   byte unsigned rx_q[$];
   int           rx_start[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      int i;
      i = k / CPB;
      if (i == 0) return 1'b0;
      if (i >= 9) return 1'b1;
      return b[i-1];
   endfunction

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.MemWrite  = 1'b1;
      bus.ALUResult = a;
      bus.WriteData = d;
      @(posedge clk);
      #1;
      bus.MemWrite = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
      @(negedge clk);
      bus.MemWrite  = 1'b0;
      bus.ALUResult = a;
      #1;
      d = bus.RdData;
      s = bus.Sel;
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        s;
      bus_read(a, d, s);
      chk(name, d, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rx_q.delete();
      rx_start.delete();
   endtask

   // Behavioural 8N1 receiver: samples mid-bit, drops any frame touched by reset or missing its stop bit
   initial begin : rx_mon
      logic [7:0] b;
      bit         ok;
      int         st;
      int         cur;
      forever begin
         @(posedge clk);
         #1;
         if (reset === 1'b1 && tx === 1'b0) begin
            b   = '0;
            ok  = 1'b1;
            st  = cyc;
            cur = 0;
            for (int j = 0; j < 9; j++) begin
               while (cur < CPB * (1 + j) + CPB / 2) begin
                  @(posedge clk);
                  #1;
                  cur++;
                  if (reset !== 1'b1) ok = 1'b0;
               end
               if (j < 8) b[j] = tx;
               else if (tx !== 1'b1) ok = 1'b0;
            end
            while (cur < FRAME - 1) begin
               @(posedge clk);
               #1;
               cur++;
               if (reset !== 1'b1) ok = 1'b0;
            end
            if (ok) begin
               rx_q.push_back(b);
               rx_start.push_back(st);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [79:0] got_tx, exp_tx, got_busy;
      logic [31:0] d;
      logic        s;
      byte unsigned mq[$];
      int          mdrops;
      logic [7:0]  b;
      int          n;

      bus.MemWrite  = 1'b0;
      bus.ALUResult = 32'h0;
      bus.WriteData = 32'h0;

      vt[0]  = '{1'b0, 32'h0,         32'h0,         A_ST,          1'b1, 32'h2};
      vt[1]  = '{1'b0, 32'h0,         32'h0,         A_CT,          1'b1, 32'h0};
      vt[2]  = '{1'b0, 32'h0,         32'h0,         A_DR,          1'b1, 32'h0};
      vt[3]  = '{1'b0, 32'h0,         32'h0,         A_TX,          1'b1, 32'h0};
      vt[4]  = '{1'b1, BASE + 32'h10, 32'h77,        BASE + 32'h10, 1'b0, 32'h0};
      vt[5]  = '{1'b1, 32'h0,         32'h77,        32'h0,         1'b0, 32'h0};
      vt[6]  = '{1'b0, 32'h0,         32'h0,         A_ST,          1'b1, 32'h2};
      vt[7]  = '{1'b1, A_ST,          32'hFFFF_FFFF, A_ST,          1'b1, 32'h2};
      vt[8]  = '{1'b1, A_CT,          32'hFFFF_FFFE, A_CT,          1'b1, 32'h0};
      vt[9]  = '{1'b1, BASE + 32'hA,  32'h1,         A_CT,          1'b1, 32'h1};
      vt[10] = '{1'b1, A_CT,          32'h0,         BASE + 32'hB,  1'b1, 32'h0};
      vt[11] = '{1'b0, 32'h0,         32'h0,         BASE + 32'h7,  1'b1, 32'h2};
      vt[12] = '{1'b0, 32'h0,         32'h0,         32'hFFFE_FFF4, 1'b0, 32'h0};

      do_reset();
      chk("reset_tx", tx, 1'b1);
      for (int i = 0; i < 13; i++) begin
         if (vt[i].wr) bus_write(vt[i].waddr, vt[i].wdata);
         bus_read(vt[i].raddr, d, s);
         chk($sformatf("vec%0d_sel", i), s, vt[i].exp_sel);
         chk($sformatf("vec%0d_rd", i), d, vt[i].exp_rd);
      end

      // Single frame with exact waveform and busy window
      do_reset();
      bus_write(A_CT, 32'h1);
      bus_write(A_TX, 32'h55);
      bus.ALUResult = A_ST;
      chk("tx_high_at_write_edge", tx, 1'b1);
      got_tx = '0; exp_tx = '0; got_busy = '0;
      for (int k = 0; k < FRAME; k++) begin
         @(posedge clk);
         #1;
         got_tx[k]   = tx;
         got_busy[k] = bus.RdData[2];
         exp_tx[k]   = frame_bit(8'h55, k);
      end
      chk("frame55_tx", got_tx, exp_tx);
      chk("frame55_busy", got_busy, {40'd0, {40{1'b1}}});
      idle(1);
      chk("frame55_idle_tx", tx, 1'b1);
      chk("frame55_idle_status", bus.RdData, 32'h2);

      // Back-to-back frames from a pre-filled FIFO
      do_reset();
      bus_write(A_TX, 32'hA5);
      bus_write(A_TX, 32'h3C);
      bus_write(A_CT, 32'h1);
      got_tx = '0; exp_tx = '0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(posedge clk);
         #1;
         got_tx[k] = tx;
         exp_tx[k] = (k < FRAME) ? frame_bit(8'hA5, k) : frame_bit(8'h3C, k - FRAME);
      end
      chk("b2b_tx", got_tx, exp_tx);
      idle(1);
      chk("b2b_rx_count", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         chk("b2b_rx0", rx_q[0], 8'hA5);
         chk("b2b_rx1", rx_q[1], 8'h3C);
         chk("b2b_gap", rx_start[1] - rx_start[0], FRAME);
      end
      rd_chk("b2b_status", A_ST, 32'h2);

      // Overflow, DROPS clear and saturation
      do_reset();
      for (int v = 8'h11; v <= 8'h15; v++) bus_write(A_TX, 32'(v));
      rd_chk("ovf_status", A_ST, 32'h401);
      rd_chk("ovf_drops", A_DR, 32'h1);
      bus_write(A_DR, 32'h0);
      rd_chk("ovf_drops_clr", A_DR, 32'h0);
      repeat (260) bus_write(A_TX, 32'hEE);
      rd_chk("drops_sat", A_DR, 32'hFF);
      bus_write(A_DR, 32'hABCD);
      rd_chk("drops_sat_clr", A_DR, 32'h0);
      rd_chk("ovf_status_kept", A_ST, 32'h401);

      // Full FIFO with a write landing on the pop edge
      do_reset();
      for (int v = 8'h21; v <= 8'h24; v++) bus_write(A_TX, 32'(v));
      bus_write(A_CT, 32'h1);
      bus_write(A_TX, 32'h99);
      rd_chk("fullpop_status", A_ST, 32'h304);
      rd_chk("fullpop_drops", A_DR, 32'h1);
      idle(4 * FRAME + 8);
      chk("fullpop_rx_count", rx_q.size(), 4);
      for (int i = 0; i < 4 && i < rx_q.size(); i++)
         chk($sformatf("fullpop_rx%0d", i), rx_q[i], 8'h21 + i);
      rd_chk("fullpop_end_status", A_ST, 32'h2);

      // Disable mid-frame, then reset mid-frame
      do_reset();
      bus_write(A_TX, 32'h12);
      bus_write(A_TX, 32'h34);
      bus_write(A_CT, 32'h1);
      idle(3 * CPB);
      bus_write(A_CT, 32'h0);
      idle(FRAME + CPB);
      chk("dis_rx_count", rx_q.size(), 1);
      if (rx_q.size() >= 1) chk("dis_rx0", rx_q[0], 8'h12);
      rd_chk("dis_status", A_ST, 32'h100);
      bus_write(A_CT, 32'h1);
      bus.ALUResult = A_ST;
      idle(2 * CPB);
      chk("rst_tx_before", tx, frame_bit(8'h34, 2 * CPB - 1));
      #2;
      reset = 1'b0;
      #1;
      chk("rst_tx_immediate", tx, 1'b1);
      chk("rst_status_immediate", bus.RdData, 32'h2);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      idle(FRAME);
      chk("rst_no_frame", rx_q.size(), 1);
      rd_chk("rst_status_after", A_ST, 32'h2);
      rd_chk("rst_ctrl_after", A_CT, 32'h0);

      // Randomized traffic against a queue model
      do_reset();
      mdrops = 0;
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) begin
               bus_write(A_ST, $urandom);
            end else begin
               b = 8'($urandom);
               bus_write(A_TX, {$urandom_range(0, 255), 16'h0, b});
               if (mq.size() < 4) mq.push_back(b);
               else if (mdrops < 255) mdrops++;
            end
         end
         rd_chk($sformatf("rnd%0d_status", r), A_ST,
                {16'h0, 8'(mq.size()), 5'h0, 1'b0, mq.size() == 0, mq.size() == 4});
         rd_chk($sformatf("rnd%0d_drops", r), A_DR, 32'(mdrops));
         if ($urandom_range(0, 1) == 1) begin
            bus_write(A_DR, $urandom);
            mdrops = 0;
         end
         rx_q.delete();
         rx_start.delete();
         bus_write(A_CT, 32'h1);
         idle(mq.size() * FRAME + 4);
         bus_write(A_CT, 32'h0);
         chk($sformatf("rnd%0d_rx_count", r), rx_q.size(), mq.size());
         for (int i = 0; i < mq.size() && i < rx_q.size(); i++)
            chk($sformatf("rnd%0d_rx%0d", r, i), rx_q[i], mq[i]);
         mq.delete();
         rd_chk($sformatf("rnd%0d_end_status", r), A_ST, 32'h2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
